// File: rtl/mem_arb_pkg.sv
// Shared definitions for the N-port memory arbiter: FSM state encodings and a width helper.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    // Bits needed to index `value` items; never less than 1 so vectors stay legal.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned w;
        w = 1;
        while ((32'd1 << w) < value) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/arb_picker.sv
// Combinational rotating picker: first set request at or after start_i wins (one-hot out).
module arb_picker
    import mem_arb_pkg::*;
#(
    parameter int unsigned NUM_PORTS = 2,
    parameter int unsigned IDX_W     = 1
) (
    input  logic [NUM_PORTS-1:0] req_i,
    input  logic [IDX_W-1:0]     start_i,
    output logic [NUM_PORTS-1:0] gnt_o,
    output logic                 valid_o
);

    localparam int unsigned PW = IDX_W + 1;

    logic [NUM_PORTS-1:0] rot;
    logic [PW-1:0]        pos;

    always_comb begin
        // Rotate so the start port sits at bit 0, find the lowest hit, then un-rotate.
        rot     = NUM_PORTS'({req_i, req_i} >> start_i);
        valid_o = 1'b0;
        pos     = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (rot[i]) begin
                valid_o = 1'b1;
                pos     = PW'(i);
            end
        end
        pos = pos + {1'b0, start_i};
        if (pos >= PW'(NUM_PORTS)) begin
            pos = pos - PW'(NUM_PORTS);
        end
        gnt_o = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            gnt_o[i] = valid_o && (pos == PW'(i));
        end
    end

endmodule

// File: rtl/mem_arbiter_nport.sv
// N-port arbiter and controller for a single-ported word memory (IDLE/ACCESS/RESP).
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise lowest index wins.
module mem_arbiter_nport
    import mem_arb_pkg::*;
#(
    parameter int unsigned NUM_PORTS   = 2,
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned MEM_LATENCY = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_PORTS-1:0]        req_i,
    input  logic [NUM_PORTS-1:0]        we_i,
    input  logic [NUM_PORTS*ADDR_W-1:0] addr_i,
    input  logic [NUM_PORTS*DATA_W-1:0] wdata_i,
    output logic [NUM_PORTS-1:0]        gnt_o,
    output logic [NUM_PORTS-1:0]        done_o,
    output logic [DATA_W-1:0]           rdata_o,
    output logic                        busy_o
);

    localparam int unsigned IDX_W = clog2(NUM_PORTS);
    localparam int unsigned CNT_W = clog2(MEM_LATENCY);
    localparam int unsigned DEPTH = 1 << ADDR_W;

    state_e               state_q;
    logic [IDX_W-1:0]     port_q;
    logic                 we_q;
    logic [ADDR_W-1:0]    addr_q;
    logic [DATA_W-1:0]    wdata_q;
    logic [DATA_W-1:0]    rdata_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [NUM_PORTS-1:0] done_q;
    logic [DATA_W-1:0]    mem_q [DEPTH];

    logic [NUM_PORTS-1:0] pick_gnt;
    logic                 pick_valid;
    logic [IDX_W-1:0]     start;
    logic [IDX_W-1:0]     win_idx;
    logic                 win_we;
    logic [ADDR_W-1:0]    win_addr;
    logic [DATA_W-1:0]    win_wdata;
    logic                 grant;
    logic                 finish;

    arb_picker #(
        .NUM_PORTS(NUM_PORTS),
        .IDX_W    (IDX_W)
    ) u_picker (
        .req_i  (req_i),
        .start_i(start),
        .gnt_o  (pick_gnt),
        .valid_o(pick_valid)
    );

    // Grant is gated by rst_n so it reads zero while reset is held.
    assign grant  = rst_n && (state_q == ST_IDLE) && pick_valid;
    assign finish = (state_q == ST_ACCESS) && (cnt_q == '0);

    always_comb begin
        win_idx   = '0;
        win_we    = 1'b0;
        win_addr  = '0;
        win_wdata = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (pick_gnt[i]) begin
                win_idx   = IDX_W'(i);
                win_we    = we_i[i];
                win_addr  = addr_i[i*ADDR_W +: ADDR_W];
                win_wdata = wdata_i[i*DATA_W +: DATA_W];
            end
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    logic [IDX_W-1:0] ptr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= IDX_W'(NUM_PORTS - 1);
        end else if (grant) begin
            ptr_q <= win_idx;
        end
    end

    assign start = (ptr_q == IDX_W'(NUM_PORTS - 1)) ? '0 : ptr_q + 1'b1;
`else
    assign start = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            port_q  <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
            done_q  <= '0;
        end else begin
            done_q <= '0;
            unique case (state_q)
                ST_IDLE: begin
                    if (grant) begin
                        port_q  <= win_idx;
                        we_q    <= win_we;
                        addr_q  <= win_addr;
                        wdata_q <= win_wdata;
                        cnt_q   <= CNT_W'(MEM_LATENCY - 1);
                        state_q <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (cnt_q == '0) begin
                        if (!we_q) begin
                            rdata_q <= mem_q[addr_q];
                        end
                        done_q[port_q] <= 1'b1;
                        state_q        <= ST_RESP;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_RESP: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Contents are deliberately not reset; a reset mid-ACCESS forces IDLE so the write is dropped.
    always_ff @(posedge clk) begin
        if (finish && we_q) begin
            mem_q[addr_q] <= wdata_q;
        end
    end

    assign gnt_o   = grant ? pick_gnt : '0;
    assign done_o  = done_q;
    assign rdata_o = rdata_q;
    assign busy_o  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_arbiter_nport.sv
// Directed bench: a 2-port MEM_LATENCY=1 instance and a 4-port MEM_LATENCY=4 instance.
module tb_mem_arbiter_nport;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]   req2, we2, gnt2, done2;
    logic [19:0]  addr2;
    logic [63:0]  wdata2;
    logic [31:0]  rdata2;
    logic         busy2;

    logic [3:0]   req4, we4, gnt4, done4;
    logic [39:0]  addr4;
    logic [127:0] wdata4;
    logic [31:0]  rdata4;
    logic         busy4;

    int checks = 0;
    int errors = 0;

    mem_arbiter_nport #(.NUM_PORTS(2), .ADDR_W(10), .DATA_W(32), .MEM_LATENCY(1)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .req_i(req2), .we_i(we2), .addr_i(addr2), .wdata_i(wdata2),
        .gnt_o(gnt2), .done_o(done2), .rdata_o(rdata2), .busy_o(busy2)
    );

    mem_arbiter_nport #(.NUM_PORTS(4), .ADDR_W(10), .DATA_W(32), .MEM_LATENCY(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .req_i(req4), .we_i(we4), .addr_i(addr4), .wdata_i(wdata4),
        .gnt_o(gnt4), .done_o(done4), .rdata_o(rdata4), .busy_o(busy4)
    );

    // Every cycle: drive at posedge+1, sample at posedge+2.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic txn2(input int p, input logic w, input logic [9:0] a, input logic [31:0] d,
                        output int lat, output logic [31:0] rd);
        bit got;
        got = 1'b0;
        lat = -1;
        rd  = '0;
        req2[p] = 1'b1; we2[p] = w; addr2[p*10 +: 10] = a; wdata2[p*32 +: 32] = d;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (gnt2[p]) begin got = 1'b1; break; end
            step();
        end
        step();
        req2[p] = 1'b0;
        if (got) begin
            for (int i = 1; i < 20; i++) begin
                #1;
                if (done2[p]) begin lat = i; rd = rdata2; break; end
                step();
            end
            step();
        end
    endtask

    task automatic txn4(input int p, input logic w, input logic [9:0] a, input logic [31:0] d,
                        output int lat, output logic [31:0] rd, output int busy_cnt);
        bit got;
        got = 1'b0;
        lat = -1;
        rd  = '0;
        busy_cnt = 0;
        req4[p] = 1'b1; we4[p] = w; addr4[p*10 +: 10] = a; wdata4[p*32 +: 32] = d;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (gnt4[p]) begin got = 1'b1; break; end
            step();
        end
        step();
        req4[p] = 1'b0;
        if (got) begin
            for (int i = 1; i < 20; i++) begin
                #1;
                if (busy4) busy_cnt++;
                if (done4[p]) begin lat = i; rd = rdata4; break; end
                step();
            end
            step();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req2 = 2'b11; we2 = '0; addr2 = '0; wdata2 = '0;
        req4 = 4'hF;  we4 = '0; addr4 = '0; wdata4 = '0;
        step(); step();
        checks++; if (gnt2 !== 2'b00) begin errors++; $display("FAIL rst_gnt2: got %b expected 00", gnt2); end
        checks++; if (done2 !== 2'b00) begin errors++; $display("FAIL rst_done2: got %b expected 00", done2); end
        checks++; if (rdata2 !== 32'h0) begin errors++; $display("FAIL rst_rdata2: got %h expected 0", rdata2); end
        checks++; if (busy2 !== 1'b0) begin errors++; $display("FAIL rst_busy2: got %b expected 0", busy2); end
        checks++; if (gnt4 !== 4'h0) begin errors++; $display("FAIL rst_gnt4: got %b expected 0000", gnt4); end
        checks++; if (done4 !== 4'h0) begin errors++; $display("FAIL rst_done4: got %b expected 0000", done4); end
        checks++; if (rdata4 !== 32'h0) begin errors++; $display("FAIL rst_rdata4: got %h expected 0", rdata4); end
        checks++; if (busy4 !== 1'b0) begin errors++; $display("FAIL rst_busy4: got %b expected 0", busy4); end
        req2 = '0; req4 = '0;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_write_read();
        int lat;
        logic [31:0] rd;
        txn2(1, 1'b1, 10'd5, 32'hDEADBEEF, lat, rd);
        checks++; if (lat !== 2) begin errors++; $display("FAIL wr_latency: got %0d expected 2", lat); end
        txn2(1, 1'b0, 10'd5, 32'h0, lat, rd);
        checks++; if (lat !== 2) begin errors++; $display("FAIL rd_latency: got %0d expected 2", lat); end
        checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data: got %h expected deadbeef", rd); end
        #1;
        checks++; if (rdata2 !== 32'hDEADBEEF) begin errors++; $display("FAIL rdata_hold: got %h expected deadbeef", rdata2); end
        step();
        txn2(0, 1'b1, 10'd6, 32'hA5A5A5A5, lat, rd);
        checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_keeps_rdata: got %h expected deadbeef", rd); end
        txn2(0, 1'b0, 10'd6, 32'h0, lat, rd);
        checks++; if (rd !== 32'hA5A5A5A5) begin errors++; $display("FAIL rd_port0: got %h expected a5a5a5a5", rd); end
    endtask

    task automatic test_priority();
        pulse_reset();
        req2 = 2'b11; we2 = 2'b01; addr2 = {10'd20, 10'd20}; wdata2 = {32'h0, 32'h00000011};
        #1;
        checks++; if (gnt2 !== 2'b01) begin errors++; $display("FAIL prio_first: got %b expected 01", gnt2); end
        step(); req2[0] = 1'b0; #1;
        checks++; if (gnt2 !== 2'b00) begin errors++; $display("FAIL prio_access_gnt: got %b expected 00", gnt2); end
        checks++; if (busy2 !== 1'b1) begin errors++; $display("FAIL prio_busy: got %b expected 1", busy2); end
        step(); #1;
        checks++; if (done2 !== 2'b01) begin errors++; $display("FAIL prio_done0: got %b expected 01", done2); end
        checks++; if (gnt2 !== 2'b00) begin errors++; $display("FAIL prio_resp_gnt: got %b expected 00", gnt2); end
        step(); #1;
        checks++; if (gnt2 !== 2'b10) begin errors++; $display("FAIL prio_second: got %b expected 10", gnt2); end
        step(); req2[1] = 1'b0;
        step(); #1;
        checks++; if (done2 !== 2'b10) begin errors++; $display("FAIL prio_done1: got %b expected 10", done2); end
        checks++; if (rdata2 !== 32'h11) begin errors++; $display("FAIL prio_rdata: got %h expected 11", rdata2); end
        step();
    endtask

    task automatic test_late_request();
        req2 = 2'b01; we2 = 2'b00; addr2 = {10'd5, 10'd6};
        #1;
        checks++; if (gnt2 !== 2'b01) begin errors++; $display("FAIL late_first: got %b expected 01", gnt2); end
        step(); req2 = 2'b10; #1;
        checks++; if (gnt2 !== 2'b00) begin errors++; $display("FAIL late_access: got %b expected 00", gnt2); end
        step(); #1;
        checks++; if (gnt2 !== 2'b00) begin errors++; $display("FAIL late_resp: got %b expected 00", gnt2); end
        step(); #1;
        checks++; if (gnt2 !== 2'b10) begin errors++; $display("FAIL late_grant: got %b expected 10", gnt2); end
        step(); req2 = 2'b00;
        step(); #1;
        checks++; if (rdata2 !== 32'hDEADBEEF) begin errors++; $display("FAIL late_rdata: got %h expected deadbeef", rdata2); end
        step();
    endtask

    task automatic test_latency4();
        int lat, bc;
        logic [31:0] rd;
        txn4(2, 1'b1, 10'd3, 32'hCAFE0003, lat, rd, bc);
        checks++; if (lat !== 5) begin errors++; $display("FAIL l4_wr_latency: got %0d expected 5", lat); end
        txn4(2, 1'b0, 10'd3, 32'h0, lat, rd, bc);
        checks++; if (lat !== 5) begin errors++; $display("FAIL l4_rd_latency: got %0d expected 5", lat); end
        checks++; if (bc !== 5) begin errors++; $display("FAIL l4_busy_cycles: got %0d expected 5", bc); end
        checks++; if (rd !== 32'hCAFE0003) begin errors++; $display("FAIL l4_rdata: got %h expected cafe0003", rd); end
        #1;
        checks++; if (busy4 !== 1'b0) begin errors++; $display("FAIL l4_idle_busy: got %b expected 0", busy4); end
        step();
    endtask

    task automatic test_arbitration();
        int rem[4];
        bit pend[4];
        int order[5];
        int when[5];
        int exp_order[5];
        int n;
        n = 0;
        rem = '{2, 1, 1, 1};
        pend = '{1'b1, 1'b1, 1'b1, 1'b1};
`ifdef ARB_ROUND_ROBIN_EN
        exp_order = '{0, 1, 2, 3, 0};
`else
        exp_order = '{0, 0, 1, 2, 3};
`endif
        pulse_reset();
        we4 = '0; addr4 = {4{10'd3}};
        for (int cyc = 0; cyc < 80 && n < 5; cyc++) begin
            for (int i = 0; i < 4; i++) req4[i] = pend[i];
            #1;
            if (gnt4 != 4'h0) begin
                checks++; if (!$onehot(gnt4)) begin errors++; $display("FAIL arb_onehot: got %b expected one-hot", gnt4); end
                for (int i = 0; i < 4; i++) if (gnt4[i]) order[n] = i;
                when[n] = cyc;
                pend[order[n]] = 1'b0;
                rem[order[n]]--;
                n++;
            end
            if (done4[0] && rem[0] > 0) pend[0] = 1'b1;
            step();
        end
        req4 = '0;
        checks++; if (n !== 5) begin errors++; $display("FAIL arb_count: got %0d expected 5", n); end
        for (int k = 0; k < n; k++) begin
            checks++;
            if (order[k] !== exp_order[k]) begin
                errors++; $display("FAIL arb_order[%0d]: got %0d expected %0d", k, order[k], exp_order[k]);
            end
            checks++;
            if (when[k] !== 6 * k) begin
                errors++; $display("FAIL arb_cycle[%0d]: got %0d expected %0d", k, when[k], 6 * k);
            end
        end
        for (int i = 0; i < 6; i++) step();
    endtask

    task automatic test_reset_mid_access();
        int lat;
        logic [31:0] rd;
        txn2(0, 1'b1, 10'd9, 32'h0, lat, rd);
        req2 = 2'b01; we2 = 2'b01; addr2[9:0] = 10'd9; wdata2[31:0] = 32'h12345678;
        #1;
        checks++; if (gnt2 !== 2'b01) begin errors++; $display("FAIL mid_grant: got %b expected 01", gnt2); end
        step(); req2 = 2'b00; #1;
        checks++; if (busy2 !== 1'b1) begin errors++; $display("FAIL mid_busy: got %b expected 1", busy2); end
        rst_n = 1'b0;
        #1;
        checks++; if (busy2 !== 1'b0) begin errors++; $display("FAIL mid_rst_busy: got %b expected 0", busy2); end
        checks++; if (rdata2 !== 32'h0) begin errors++; $display("FAIL mid_rst_rdata: got %h expected 0", rdata2); end
        checks++; if (done2 !== 2'b00) begin errors++; $display("FAIL mid_rst_done: got %b expected 00", done2); end
        step();
        checks++; if (done2 !== 2'b00) begin errors++; $display("FAIL mid_no_done: got %b expected 00", done2); end
        rst_n = 1'b1;
        step();
        txn2(0, 1'b0, 10'd9, 32'h0, lat, rd);
        checks++; if (lat !== 2) begin errors++; $display("FAIL mid_rd_latency: got %0d expected 2", lat); end
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL mid_write_aborted: got %h expected 0", rd); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_priority();
        test_late_request();
        test_latency4();
        test_arbitration();
        test_reset_mid_access();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mem_arbiter_nport.md
# mem_arbiter_nport

Parametrised N-port main-memory arbiter and controller for the pipelined MIPS32 core. It replaces the fixed two-way I-cache/D-cache selection with a request/grant/done handshake to a single-ported word memory. Any number of cache or DMA requesters are supported, with configurable access latency and selectable arbitration policy. It sits between the cache miss/write-back interfaces and the main memory array, which it owns.

## Interface
- NUM_PORTS, 2 — number of requesters (≥2); port 0 = D-cache, port 1 = I-cache
- ADDR_W, 10 — word address width; memory depth 2^ADDR_W words
- DATA_W, 32 — word width
- MEM_LATENCY, 1 — cycles in ACCESS state (≥1)
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req  in  NUM_PORTS  per-port request level; held until own gnt
- we  in  NUM_PORTS  per-port write enable (1=write, 0=read), valid with req
- addr  in  NUM_PORTS*ADDR_W  packed addresses, port i at [i*ADDR_W +: ADDR_W]
- wdata  in  NUM_PORTS*DATA_W  packed write data, same packing
- gnt  out  NUM_PORTS  one-hot grant, one cycle, combinational in IDLE
- done  out  NUM_PORTS  one-hot completion pulse, registered, one cycle
- rdata  out  DATA_W  read data, valid while done is high; holds the last value otherwise
- busy  out  1  high in ACCESS and RESP

## Operation
- States: IDLE, ACCESS, RESP.
- IDLE with any req bit set:
  - gnt of the winner is high this cycle.
  - At the edge: latch port index, we, addr, wdata; counter ← MEM_LATENCY-1; go to ACCESS.
- IDLE with no req: gnt = 0; remain in IDLE.
- ACCESS:
  - Counter decrements each edge.
  - At the edge where counter==0:
    - Write: mem[addr] ← wdata.
    - Read: rdata ← mem[addr].
    - Go to RESP.
- RESP:
  - done[latched port] = 1.
  - On a write, rdata is unchanged.
  - Next edge → IDLE.
- No grant is issued in ACCESS or RESP; the next grant comes no earlier than the cycle after RESP.
- A requester must not change we/addr/wdata while req is high and gnt is low. It deasserts req, or presents a new request, in the cycle after gnt.
- req on a port that is already in flight is a protocol violation; behaviour is undefined and the bench flags it.
- Arbitration is defined under Configuration. The pointer updates only on grant.
- Memory contents are not reset. Out-of-range addresses are impossible by width.

## Timing
- Reset values: gnt=0, done=0, rdata=0, busy=0, state=IDLE, counter=0, RR pointer=NUM_PORTS-1.
- gnt in cycle t → done in cycle t+MEM_LATENCY+1 → IDLE in cycle t+MEM_LATENCY+2.
- Peak throughput: one transaction per MEM_LATENCY+2 cycles.
- Reset asserted mid-ACCESS:
  - The transaction is aborted and its write is not performed.
  - done is never pulsed for it.
  - Outputs go to reset values immediately (asynchronously).
- Reset asserted in the RESP cycle: the done pulse is cut short asynchronously; the memory write has already occurred.
- Simultaneous requests are resolved in the same cycle. Losers see gnt=0 and keep holding.

## Configuration
- ARB_ROUND_ROBIN_EN defined:
  - Round-robin arbitration.
  - The search starts at (last granted port + 1) mod NUM_PORTS.
  - Port 0 wins first after reset.
  - No requester waits more than NUM_PORTS-1 grants.
- ARB_ROUND_ROBIN_EN undefined:
  - Fixed priority; the lowest index wins, so the D-cache on port 0 beats the I-cache.
  - The pointer register is not built.

## Structure
- Shared package mem_arb_pkg holds:
  - state encodings ST_IDLE=2'd0, ST_ACCESS=2'd1, ST_RESP=2'd2;
  - a clog2 function for the port-index and counter widths.
- Sub-module arb_picker:
  - Combinational: req vector plus start index in, one-hot winner plus valid out.
  - Fixed priority uses start=0.
  - Instantiated once.
- Memory array, FSM, latency counter and response register live in the top module.

## Test plan
- Single write then read, MEM_LATENCY=1:
  - port 1 writes 32'hDEADBEEF to address 5 → gnt[1] in cycle t, done[1] at t+2.
  - Read of address 5 → rdata=32'hDEADBEEF with done[1].
- Simultaneous req on ports 0 and 1, fixed priority:
  - port 0 is granted first.
  - port 1 is granted at the first IDLE cycle after port 0's RESP.
- ARB_ROUND_ROBIN_EN, NUM_PORTS=4, all ports requesting continuously → grant order 0,1,2,3,0, one grant every MEM_LATENCY+2 cycles.
- MEM_LATENCY=4 read → busy high for 5 cycles and done exactly 5 cycles after gnt.
- rst_n low during ACCESS of a write of 32'h12345678 to address 9 (address preloaded with 32'h0):
  - outputs go to 0 at once;
  - a subsequent read of address 9 returns 32'h0.
- Late request during ACCESS → no gnt until the cycle after RESP; the request is honoured then.
